// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand feeder.
// Holds the FSM encoding and the step-count helper used for the counter width.
package systolic_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One step per diagonal wavefront: K operands plus N-1 skew on each edge.
  function automatic int STEPS(input int n, input int k);
    return k + 2 * n - 2;
  endfunction

endpackage

// File: rtl/feeder_operand_buf.sv
// A/B operand register file with a skewed, zero-padded combinational read.
// Write latency one cycle; read is combinational from step; no backpressure.
module feeder_operand_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int SW         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(K)-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [SW-1:0]           step,
  output logic [N*DATA_WIDTH-1:0] a_vals,
  output logic [N*DATA_WIDTH-1:0] b_vals
);

  localparam int KW = $clog2(K);

  // b_mem is stored column-major so both tiles index as [edge slice][k].
  logic [DATA_WIDTH-1:0] a_mem [N][K];
  logic [DATA_WIDTH-1:0] b_mem [N][K];

  logic row_ok, idx_ok;
  assign row_ok = int'(wr_row) < N;
  assign idx_ok = int'(wr_idx) < K;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < K; k++) begin
          a_mem[i][k] <= '0;
          b_mem[i][k] <= '0;
        end
      end
    end else if (wr_en && row_ok && idx_ok) begin
      if (!wr_sel) a_mem[wr_row][wr_idx] <= wr_data;
      else         b_mem[wr_row][wr_idx] <= wr_data;
    end
  end

  always_comb begin
    a_vals = '0;
    b_vals = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(step) >= i && int'(step) - i < K) begin
        a_vals[i*DATA_WIDTH +: DATA_WIDTH] = a_mem[i][KW'(int'(step) - i)];
        b_vals[i*DATA_WIDTH +: DATA_WIDTH] = b_mem[i][KW'(int'(step) - i)];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Drives skewed A/B edge streams and LOAD/SHIFT pattern into the MAC array.
// Pass latency 2*STEPS+2 cycles from start to done; no backpressure, start ignored while busy.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int N          = 4,
  parameter int K          = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(K)-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    arr_clr,
  output logic                    load,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    done
);

  localparam int STEPS_N = STEPS(N, K);
  localparam int SW      = (STEPS_N > 1) ? $clog2(STEPS_N) : 1;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic            wr_commit;
  logic [N*DATA_WIDTH-1:0] a_vals, b_vals;

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        state_nxt = ST_LOAD;
        s_nxt     = '0;
      end
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (s == SW'(STEPS_N - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_LOAD;
          s_nxt     = s + SW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        s_nxt     = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        s_nxt     = '0;
      end
    endcase
  end

  // A write in the same IDLE cycle as start lands before the first LOAD reads it.
  assign wr_commit = wr_en && (state == ST_IDLE);

  feeder_operand_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .N         (N),
    .K         (K),
    .SW        (SW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_commit),
    .wr_sel (wr_sel),
    .wr_row (wr_row),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .step   (s_nxt),
    .a_vals (a_vals),
    .b_vals (b_vals)
  );

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      s       <= '0;
      busy    <= 1'b0;
      arr_clr <= 1'b0;
      load    <= 1'b0;
      done    <= 1'b0;
      a_edge  <= '0;
      b_edge  <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      busy    <= (state_nxt != ST_IDLE);
      arr_clr <= (state_nxt == ST_CLEAR);
      load    <= (state_nxt == ST_LOAD);
      done    <= (state_nxt == ST_DONE);
      if (state_nxt == ST_LOAD || state_nxt == ST_SHIFT) begin
        a_edge <= a_vals;
        b_edge <= b_vals;
      end else begin
        a_edge <= '0;
        b_edge <= '0;
      end
    end
  end

endmodule
